mem_stage_sb: RTL and testbench
===============================

# mem_stage_sb

Parametrised memory stage for the pipelined RISC-V core: it holds the M-stage pipeline register and drives a variable-latency data-memory port with a req/ack handshake. Stores retire into a DEPTH-entry FIFO store buffer that drains to memory in the background. Loads stall only on a word-address conflict with a buffered store or while memory is busy. Writeback selection (load data, PC+4, ALU result) feeds the W stage.

## Interface
- XLEN, 32, datapath and address width
- SB_DEPTH, 4, store-buffer entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  X stage presents an instruction
- in_ready  out  1  M stage accepts this cycle; low = stall upstream
- pc_x, alu_x, rs2_x, inst_x  in  XLEN each  X-stage values
- wb_w_bypass  in  XLEN  W-stage result for store-data bypass
- wm_bypass  in  1  select wb_w_bypass as store data
- out_valid  out  1  M instruction completes this cycle
- inst_m, alu_m  out  XLEN  M-register contents
- wb_m  out  XLEN  writeback value, valid when out_valid
- sb_empty  out  1  store buffer empty (for fences)
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = store, 0 = load
- mem_addr, mem_wdata  out  XLEN  request address/data
- mem_size  out  2  the project's `BYTE/`HALFWORD/`WORD encoding from funct3
- mem_rdun  out  1  unsigned load (funct3 100/101)
- mem_ack  in  1  request done; mem_rdata valid this cycle
- mem_rdata  in  XLEN  extended load data

## Operation
- M register (valid_m, inst_m, pc_m, alu_m, rs2_m) loads when in_valid && in_ready; valid_m clears when an instruction completes and none is accepted.
- in_ready = !valid_m || completing this cycle.
- Classes by inst_m[6:0]: `LCC load, `SCC store, `JAL/`JALR link, else ALU.
- ALU/link: complete in first M cycle. wb_m = pc_m+4 for link, alu_m otherwise.
- Store: push {alu_m, size, data = wm_bypass ? wb_w_bypass : rs2_m} into the SB and complete the same cycle. Push is allowed if count < SB_DEPTH or a pop occurs in the same cycle. Otherwise hold.
- Load hazard: any valid SB entry with addr[XLEN-1:2] == alu_m[XLEN-1:2]. The load holds until no entry matches.
- Memory FSM:
  - IDLE: a hazard-free load in M → issue load, go to LOAD_WAIT. Otherwise, if the SB is non-empty → issue the head store, go to ST_WAIT.
  - Load has priority over drain.
- LOAD_WAIT: mem_req=1, mem_we=0, mem_addr=alu_m. On mem_ack: wb_m = mem_rdata, out_valid=1, load completes, go to IDLE.
- ST_WAIT: mem_req=1, mem_we=1, fields from the SB head. On mem_ack: pop, go to IDLE.
- Request fields stay stable while mem_req=1 and mem_ack=0.
- Count is incremented and decremented with wrap-free pointers mod SB_DEPTH. Push and pop in the same cycle leave count unchanged.

## Timing
- Reset (async assert, sync-safe release):
  - valid_m=0, SB empty (count=0, pointers 0), FSM IDLE.
  - Outputs: out_valid=0, mem_req=0, mem_we=0, sb_empty=1, in_ready=1.
  - inst_m, alu_m, wb_m, mem_addr, mem_wdata, mem_size, mem_rdun are all 0.
- ALU/link/store (SB not full): 1 cycle in M; out_valid in the cycle after capture.
- Load: issued on the first IDLE, hazard-free cycle. Completes on the mem_ack cycle (minimum 1 cycle if ack arrives with req).
- Minimum one idle cycle between memory transactions (ack cycle returns to IDLE).
- Reset asserted mid-transaction abandons the request. mem_req drops immediately and the SB contents are discarded.

## Test plan
- ALU op alu_x=0x100, then JAL at pc_x=0x40 → wb_m=0x100, then 0x44; one out_valid per cycle, in_ready stays 1.
- 5 stores with SB_DEPTH=4 and mem_ack held low → first 4 complete on consecutive cycles, 5th holds with in_ready=0. Raise mem_ack for 1 cycle → pop and push in the same cycle, count stays 4.
- Store byte 0xAB to 0x203 in SB, then load word 0x200 → load waits until the store drains (mem_we=1, size `BYTE), then issues; wb_m=mem_rdata.
- Store to 0x300 buffered, load from 0x400 → load issues first (mem_we=0, addr 0x400) ahead of the drain.
- Store with wm_bypass=1, rs2_x=0x11, wb_w_bypass=0x22 → buffered data 0x22.
- rst_n low during ST_WAIT with 3 entries → mem_req=0 and sb_empty=1 asynchronously; after release, no stale store is issued.

Source files
------------

// File: rtl/mem_stage_sb_if.sv
// Data-memory request/acknowledge port of the M stage.
// The stage drives the request side (master); memory returns ack/rdata (slave).
interface mem_stage_sb_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [1:0]      mem_size;
    logic            mem_rdun;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_size, mem_rdun,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_size, mem_rdun,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_sb.sv
// M stage of the pipelined RISC-V core: pipeline register, FIFO store buffer
// draining in the background, and a req/ack data-memory port where loads win over drains.
module mem_stage_sb #(
    parameter int XLEN     = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pc_x,
    input  logic [XLEN-1:0]   alu_x,
    input  logic [XLEN-1:0]   rs2_x,
    input  logic [XLEN-1:0]   inst_x,
    input  logic [XLEN-1:0]   wb_w_bypass,
    input  logic              wm_bypass,
    output logic              out_valid,
    output logic [XLEN-1:0]   inst_m,
    output logic [XLEN-1:0]   alu_m,
    output logic [XLEN-1:0]   wb_m,
    output logic              sb_empty,
    mem_stage_sb_if.master    mem
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(SB_DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [6:0]    OP_LOAD   = 7'b0000011;
    localparam logic [6:0]    OP_STORE  = 7'b0100011;
    localparam logic [6:0]    OP_JAL    = 7'b1101111;
    localparam logic [6:0]    OP_JALR   = 7'b1100111;
    localparam logic [XLEN-1:0] LINK_OFS = {{(XLEN-3){1'b0}}, 3'd4};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD_WAIT = 2'd1,
        S_ST_WAIT   = 2'd2
    } state_e;

    logic            valid_q;
    logic [XLEN-1:0] inst_q, pc_q, alu_q, rs2_q;

    logic [XLEN-1:0] sb_addr_q [SB_DEPTH];
    logic [XLEN-1:0] sb_data_q [SB_DEPTH];
    logic [1:0]      sb_size_q [SB_DEPTH];
    logic [SB_DEPTH-1:0] sb_vld_q;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;

    state_e          state_q;
    logic            mem_req_q, mem_we_q, mem_rdun_q;
    logic [XLEN-1:0] mem_addr_q, mem_wdata_q;
    logic [1:0]      mem_size_q;

    logic            is_load_s, is_store_s, is_link_s;
    logic            hazard_s, pop_s, push_s, complete_s;
    logic [XLEN-1:0] store_data_s, wb_s;

    // Instruction class, store-buffer hazard, push/pop and completion decisions.
    always_comb begin
        is_load_s    = (inst_q[6:0] == OP_LOAD);
        is_store_s   = (inst_q[6:0] == OP_STORE);
        is_link_s    = (inst_q[6:0] == OP_JAL) || (inst_q[6:0] == OP_JALR);
        hazard_s     = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            hazard_s = hazard_s |
                       (sb_vld_q[PW'(i)] && (sb_addr_q[PW'(i)][XLEN-1:2] == alu_q[XLEN-1:2]));
        end
        pop_s        = (state_q == S_ST_WAIT) && mem.mem_ack;
        // A full buffer still accepts the push when the head retires in the same cycle.
        push_s       = valid_q && is_store_s && ((count_q != DEPTH_C) || pop_s);
        store_data_s = wm_bypass ? wb_w_bypass : rs2_q;
        if (is_load_s) begin
            complete_s = valid_q && (state_q == S_LOAD_WAIT) && mem.mem_ack;
            wb_s       = mem.mem_rdata;
        end else if (is_store_s) begin
            complete_s = push_s;
            wb_s       = alu_q;
        end else if (is_link_s) begin
            complete_s = valid_q;
            wb_s       = pc_q + LINK_OFS;
        end else begin
            complete_s = valid_q;
            wb_s       = alu_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    assign in_ready  = !valid_q || complete_s;
    assign out_valid = complete_s;
    assign wb_m      = wb_s;
    assign inst_m    = inst_q;
    assign alu_m     = alu_q;
    assign sb_empty  = (count_q == CNT_ZERO);

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_size  = mem_size_q;
    assign mem.mem_rdun  = mem_rdun_q;

    // M pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
            alu_q   <= '0;
            rs2_q   <= '0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            inst_q  <= inst_x;
            pc_q    <= pc_x;
            alu_q   <= alu_x;
            rs2_q   <= rs2_x;
        end else if (complete_s) begin
            valid_q <= 1'b0;
        end
    end

    // Store buffer entries and pointers; a same-cycle push overrides the pop's clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sb_vld_q <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_addr_q[i] <= '0;
                sb_data_q[i] <= '0;
                sb_size_q[i] <= 2'b00;
            end
        end else begin
            count_q <= count_d;
            if (pop_s) begin
                sb_vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q           <= rd_ptr_q + PTR_ONE;
            end
            if (push_s) begin
                sb_vld_q[wr_ptr_q]  <= 1'b1;
                sb_addr_q[wr_ptr_q] <= alu_q;
                sb_data_q[wr_ptr_q] <= store_data_s;
                sb_size_q[wr_ptr_q] <= inst_q[13:12];
                wr_ptr_q            <= wr_ptr_q + PTR_ONE;
            end
        end
    end

    // Memory port FSM with registered request fields held until ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= 2'b00;
            mem_rdun_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_q && is_load_s && !hazard_s) begin
                        state_q     <= S_LOAD_WAIT;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= alu_q;
                        mem_wdata_q <= '0;
                        mem_size_q  <= inst_q[13:12];
                        mem_rdun_q  <= inst_q[14];
                    end else if (count_q != CNT_ZERO) begin
                        state_q     <= S_ST_WAIT;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= sb_addr_q[rd_ptr_q];
                        mem_wdata_q <= sb_data_q[rd_ptr_q];
                        mem_size_q  <= sb_size_q[rd_ptr_q];
                        mem_rdun_q  <= 1'b0;
                    end else begin
                        mem_req_q   <= 1'b0;
                    end
                end
                S_LOAD_WAIT, S_ST_WAIT: begin
                    if (mem.mem_ack) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                    end else begin
                        mem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_sb.sv
// Scoreboard bench for mem_stage_sb: program-order byte-memory reference model,
// randomly acking memory responder, and directed store-buffer/hazard/reset scenarios.
`timescale 1ns/1ps
module tb_mem_stage_sb;
    localparam int XLEN = 32;
    localparam int SB_DEPTH = 4;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            in_valid, in_ready, wm_bypass, out_valid, sb_empty;
    logic [XLEN-1:0] pc_x, alu_x, rs2_x, inst_x, wb_w_bypass, inst_m, alu_m, wb_m;

    mem_stage_sb_if #(.XLEN(XLEN)) mif ();

    mem_stage_sb #(.XLEN(XLEN), .SB_DEPTH(SB_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pc_x(pc_x), .alu_x(alu_x), .rs2_x(rs2_x), .inst_x(inst_x),
        .wb_w_bypass(wb_w_bypass), .wm_bypass(wm_bypass), .out_valid(out_valid),
        .inst_m(inst_m), .alu_m(alu_m), .wb_m(wb_m), .sb_empty(sb_empty), .mem(mif)
    );

    typedef struct { logic [31:0] inst; logic [31:0] wb; bit chk_wb; } exp_t;
    typedef struct { bit we; logic [31:0] addr; logic [1:0] size; logic [31:0] wdata; bit rdun; } txn_t;
    typedef enum int { ACK_RAND, ACK_NEVER, ACK_ONCE } ack_mode_t;

    exp_t      exp_q[$];
    txn_t      log_q[$];
    ack_mode_t ack_mode = ACK_RAND;
    int        n_checks = 0;
    int        n_fail = 0;
    logic [7:0] ref_mem [int unsigned];
    logic [7:0] rsp_mem [int unsigned];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] rsp_rd(input logic [31:0] a);
        return rsp_mem.exists(a) ? rsp_mem[a] : init_byte(a);
    endfunction

    // Architectural load result: little-endian bytes, sign/zero extension from funct3.
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] w;
        w = {ref_rd(a + 32'd3), ref_rd(a + 32'd2), ref_rd(a + 32'd1), ref_rd(a)};
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic void ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < (1 << sz); i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [2:0] f3);
        logic [31:0] r;
        r = $urandom();
        return {r[31:15], f3, r[11:7], op};
    endfunction

    // Present one instruction in X until accepted, then record its expected result in program order.
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rs2, input bit bp, input logic [31:0] bpv, output int waits);
        exp_t e;
        bit   acc;
        inst_x = inst; pc_x = pc; alu_x = alu; rs2_x = rs2; in_valid = 1'b1;
        waits = 0;
        acc = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (!acc) begin
                waits++;
                if (waits > 400) begin
                    n_checks++; n_fail++;
                    $display("FAIL issue_timeout: in_ready low for %0d cycles, required acceptance", waits);
                    break;
                end
            end
        end
        in_valid = 1'b0;
        wm_bypass = bp;
        wb_w_bypass = bpv;
        if (acc) begin
            e.inst = inst;
            e.chk_wb = 1'b1;
            case (inst[6:0])
                OP_LOAD:  e.wb = ref_load(alu, inst[14:12]);
                OP_STORE: begin
                    ref_store(alu, inst[13:12], bp ? bpv : rs2);
                    e.wb = alu;
                    e.chk_wb = 1'b0;
                end
                OP_JAL, OP_JALR: e.wb = pc + 32'd4;
                default:  e.wb = alu;
            endcase
            exp_q.push_back(e);
        end
    endtask

    task automatic quiesce(input string tag);
        int n;
        n = 0;
        while (!(sb_empty && !mif.mem_req && exp_q.size() == 0)) begin
            @(negedge clk);
            n++;
            if (n > 1000) begin
                n_checks++; n_fail++;
                $display("FAIL quiesce_%s: still busy after %0d cycles, required idle", tag, n);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Memory responder: logs each request, checks it stays stable, acks per ack_mode.
    initial begin
        bit   in_txn;
        bit   ack;
        txn_t cur;
        in_txn = 1'b0;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mif.mem_ack = 1'b0;
            mif.mem_rdata = $urandom();
            if (rst_n && mif.mem_req) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    cur.we = mif.mem_we; cur.addr = mif.mem_addr; cur.size = mif.mem_size;
                    cur.wdata = mif.mem_wdata; cur.rdun = mif.mem_rdun;
                    log_q.push_back(cur);
                end else begin
                    check1("req_we_stable", mif.mem_we, cur.we);
                    check("req_addr_stable", mif.mem_addr, cur.addr);
                    check("req_wdata_stable", mif.mem_wdata, cur.wdata);
                    check("req_size_stable", {30'd0, mif.mem_size}, {30'd0, cur.size});
                end
                case (ack_mode)
                    ACK_RAND: ack = ($urandom_range(0, 2) == 0);
                    ACK_ONCE: begin ack = 1'b1; ack_mode = ACK_NEVER; end
                    default:  ack = 1'b0;
                endcase
                if (ack) begin
                    if (cur.we) begin
                        for (int i = 0; i < (1 << cur.size); i++) rsp_mem[cur.addr + 32'(i)] = cur.wdata[8*i +: 8];
                    end else begin
                        logic [31:0] w;
                        w = {rsp_rd(cur.addr + 32'd3), rsp_rd(cur.addr + 32'd2), rsp_rd(cur.addr + 32'd1), rsp_rd(cur.addr)};
                        case (cur.size)
                            2'b00:   mif.mem_rdata = cur.rdun ? {24'd0, w[7:0]} : {{24{w[7]}}, w[7:0]};
                            2'b01:   mif.mem_rdata = cur.rdun ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
                            default: mif.mem_rdata = w;
                        endcase
                    end
                    mif.mem_ack = 1'b1;
                    in_txn = 1'b0;
                end
            end else begin
                in_txn = 1'b0;
            end
        end
    end

    // Monitor: every completing instruction is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_out_valid: inst_m 0x%08h, required no completion", inst_m);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_m", inst_m, e.inst);
                    if (e.chk_wb) check("wb_m", wb_m, e.wb);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [2:0] ld_f3 [5];
        int mism;
        ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
        in_valid = 1'b0; pc_x = '0; alu_x = '0; rs2_x = '0; inst_x = '0;
        wb_w_bypass = '0; wm_bypass = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_mem_req", mif.mem_req, 1'b0);
        check1("rst_mem_we", mif.mem_we, 1'b0);
        check1("rst_sb_empty", sb_empty, 1'b1);
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_mem_rdun", mif.mem_rdun, 1'b0);
        check("rst_inst_m", inst_m, 32'd0);
        check("rst_alu_m", alu_m, 32'd0);
        check("rst_wb_m", wb_m, 32'd0);
        check("rst_mem_addr", mif.mem_addr, 32'd0);
        check("rst_mem_wdata", mif.mem_wdata, 32'd0);
        check("rst_mem_size", {30'd0, mif.mem_size}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU then JAL back to back
        issue(mk_inst(OP_ALU, 3'b000), 32'h10, 32'h100, 32'h0, 1'b0, 32'h0, w);
        check("alu_waits", w, 32'd0);
        issue(mk_inst(OP_JAL, 3'b000), 32'h40, 32'h5555, 32'h0, 1'b0, 32'h0, w);
        check("jal_waits", w, 32'd0);
        quiesce("alu_jal");

        // Fill the store buffer with memory stalled
        ack_mode = ACK_NEVER;
        for (int i = 0; i < 5; i++) begin
            issue(mk_inst(OP_STORE, 3'b010), 32'h0, 32'h280 + 32'(4*i), $urandom(), 1'b0, 32'h0, w);
            check("sb_fill_waits", w, 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("sb_full_in_ready", in_ready, 1'b0);
            check1("sb_full_out_valid", out_valid, 1'b0);
        end
        check1("sb_full_not_empty", sb_empty, 1'b0);
        ack_mode = ACK_ONCE;
        @(negedge clk);
        check1("pop_push_out_valid", out_valid, 1'b1);
        check1("pop_push_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        issue(mk_inst(OP_STORE, 3'b010), 32'h0, 32'h2A0, $urandom(), 1'b0, 32'h0, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("still_full_in_ready", in_ready, 1'b0);
        end
        ack_mode = ACK_RAND;
        quiesce("sb_fill");

        // Load conflicting with a buffered byte store waits for the drain
        log_q.delete();
        issue(mk_inst(OP_STORE, 3'b000), 32'h0, 32'h203, 32'h123456AB, 1'b0, 32'h0, w);
        issue(mk_inst(OP_LOAD, 3'b010), 32'h0, 32'h200, 32'h0, 1'b0, 32'h0, w);
        quiesce("hazard");
        check("haz_txn_count", log_q.size(), 32'd2);
        if (log_q.size() == 2) begin
            check1("haz_first_we", log_q[0].we, 1'b1);
            check("haz_first_addr", log_q[0].addr, 32'h203);
            check("haz_first_size", {30'd0, log_q[0].size}, 32'd0);
            check("haz_first_data", {24'd0, log_q[0].wdata[7:0]}, 32'hAB);
            check1("haz_second_we", log_q[1].we, 1'b0);
            check("haz_second_addr", log_q[1].addr, 32'h200);
        end

        // Non-conflicting load overtakes a buffered store
        log_q.delete();
        issue(mk_inst(OP_STORE, 3'b010), 32'h0, 32'h300, $urandom(), 1'b0, 32'h0, w);
        issue(mk_inst(OP_LOAD, 3'b010), 32'h0, 32'h400, 32'h0, 1'b0, 32'h0, w);
        quiesce("priority");
        check("prio_txn_count", log_q.size(), 32'd2);
        if (log_q.size() == 2) begin
            check1("prio_first_we", log_q[0].we, 1'b0);
            check("prio_first_addr", log_q[0].addr, 32'h400);
            check1("prio_second_we", log_q[1].we, 1'b1);
            check("prio_second_addr", log_q[1].addr, 32'h300);
        end

        // Store data taken from the W-stage bypass
        log_q.delete();
        issue(mk_inst(OP_STORE, 3'b010), 32'h0, 32'h340, 32'h11, 1'b1, 32'h22, w);
        issue(mk_inst(OP_LOAD, 3'b010), 32'h0, 32'h340, 32'h0, 1'b0, 32'h0, w);
        quiesce("bypass");
        check("bypass_txn_count", log_q.size(), 32'd2);
        if (log_q.size() == 2) check("bypass_wdata", log_q[0].wdata, 32'h22);

        // Reset in the middle of a store drain
        ack_mode = ACK_NEVER;
        for (int i = 0; i < 3; i++)
            issue(mk_inst(OP_STORE, 3'b010), 32'h0, 32'h380 + 32'(4*i), $urandom(), 1'b0, 32'h0, w);
        repeat (3) @(negedge clk);
        check1("st_wait_req", mif.mem_req, 1'b1);
        check1("st_wait_we", mif.mem_we, 1'b1);
        check1("st_wait_not_empty", sb_empty, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check1("async_rst_req", mif.mem_req, 1'b0);
        check1("async_rst_sb_empty", sb_empty, 1'b1);
        check1("async_rst_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ref_mem.delete(); rsp_mem.delete(); exp_q.delete(); log_q.delete();
        ack_mode = ACK_RAND;
        repeat (20) @(posedge clk);
        check("post_rst_no_txn", log_q.size(), 32'd0);
        check1("post_rst_sb_empty", sb_empty, 1'b1);
        @(posedge clk); #1;

        // Random instruction mix over a small address window
        for (int n = 0; n < 300; n++) begin
            int cls;
            logic [31:0] a;
            logic [2:0]  f3;
            cls = $urandom_range(0, 9);
            a = 32'h200 + 32'($urandom_range(0, 63));
            if (cls <= 2) begin
                f3 = ld_f3[$urandom_range(0, 4)];
                a = a & ~((32'd1 << f3[1:0]) - 32'd1);
                issue(mk_inst(OP_LOAD, f3), $urandom(), a, $urandom(), $urandom_range(0, 1) == 1, $urandom(), w);
            end else if (cls <= 5) begin
                f3 = 3'($urandom_range(0, 2));
                a = a & ~((32'd1 << f3[1:0]) - 32'd1);
                issue(mk_inst(OP_STORE, f3), $urandom(), a, $urandom(), $urandom_range(0, 1) == 1, $urandom(), w);
            end else if (cls == 6) begin
                issue(mk_inst(OP_JAL, 3'($urandom())), $urandom(), $urandom(), $urandom(), 1'b0, 32'h0, w);
            end else if (cls == 7) begin
                issue(mk_inst(OP_JALR, 3'b000), $urandom(), $urandom(), $urandom(), 1'b0, 32'h0, w);
            end else begin
                issue(mk_inst(OP_ALU, 3'($urandom())), $urandom(), $urandom(), $urandom(), 1'b0, 32'h0, w);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        quiesce("random");
        check("scoreboard_drained", exp_q.size(), 32'd0);
        mism = 0;
        for (int a = 32'h200; a < 32'h300; a++)
            if (ref_rd(32'(a)) !== rsp_rd(32'(a))) mism++;
        check("final_memory_image", mism, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
